buspirate_top: RTL and testbench

BUSPIRATE_TOP -- requirements
Module: buspirate_top

---
 rtl/buspirate_pkg.sv | 44 ++++
 rtl/buspirate_iobuf.sv | 41 ++++
 rtl/buspirate_top.sv | 244 ++++++++++++++++++++++++
 tb/tb_buspirate_top.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/buspirate_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : buspirate_pkg
//  Description : Shared constants for the bus-pirate I/O block: register
//                word addresses, ID value and pin index ordering.
//  Revision    : 1.0 - initial release
// ============================================================================
package buspirate_pkg;

    // Register word addresses on the MCU bus
    localparam int unsigned REG_ID       = 32'h00;
    localparam int unsigned REG_DIR      = 32'h01;
    localparam int unsigned REG_OD       = 32'h02;
    localparam int unsigned REG_OUT      = 32'h03;
    localparam int unsigned REG_IN       = 32'h04;
    localparam int unsigned REG_LAT      = 32'h05;
    localparam int unsigned REG_IRQEN    = 32'h06;
    localparam int unsigned REG_IRQSTAT  = 32'h07;
    localparam int unsigned REG_EDGEMASK = 32'h08;
    localparam int unsigned REG_SWIRQ    = 32'h09;
    localparam int unsigned REG_SCRATCH  = 32'h0A;

    // Fixed identification word ("BP")
    localparam logic [15:0] C_ID_VALUE = 16'h4250;

    localparam int NUM_PINS = 5;

    // Bit position of each pin in every 5-bit pin register
    typedef enum logic [2:0] {
        PIN_MOSI  = 3'd0,
        PIN_CLOCK = 3'd1,
        PIN_MISO  = 3'd2,
        PIN_CS    = 3'd3,
        PIN_AUX   = 3'd4
    } pin_idx_e;

    // Bit position of each interrupt source in IRQEN / IRQSTAT
    typedef enum logic [0:0] {
        IRQ_EDGE = 1'b0,
        IRQ_SW   = 1'b1
    } irq_idx_e;

endpackage : buspirate_pkg
`default_nettype wire

// File: rtl/buspirate_iobuf.sv
`default_nettype none
// ============================================================================
//  Module      : buspirate_iobuf
//  Description : One pin buffer: maps DIR/OD/OUT onto the external buffer
//                direction, open-drain flag and data line, and brings the
//                pin level back into the clock domain through two flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module buspirate_iobuf (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic dir_i,
    input  logic od_i,
    input  logic out_i,
    output logic bufdir_o,
    output logic bufod_o,
    output logic in_o,
    inout  wire  bufio_io
);

    logic       w_drive;
    logic [1:0] sync_q;

    // Open-drain pins only actively drive a low; a high releases the line.
    assign w_drive  = od_i ? (dir_i & ~out_i) : dir_i;
    assign bufdir_o = w_drive;
    assign bufod_o  = od_i;
    assign bufio_io = w_drive ? (out_i & ~od_i) : 1'bz;
    assign in_o     = sync_q[1];

    // Two-flop synchronizer for the pin level
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], bufio_io};
        end
    end

endmodule : buspirate_iobuf
`default_nettype wire

// File: rtl/buspirate_top.sv
`default_nettype none
// ============================================================================
//  Module      : buspirate_top
//  Description : Asynchronous MCU-bus slave with a small register file that
//                controls five pin buffers, an 8-bit latch and two interrupts.
//  Revision    : 1.0 - initial release
// ============================================================================
module buspirate_top
    import buspirate_pkg::*;
#(
    parameter int MC_DATA_WIDTH = 16,
    parameter int MC_ADD_WIDTH  = 6
) (
    input  logic                     clock,
    input  logic                     reset,
    output logic                     bufdir_mosi,
    output logic                     bufdir_clock,
    output logic                     bufdir_miso,
    output logic                     bufdir_cs,
    output logic                     bufdir_aux,
    output logic                     bufod_mosi,
    output logic                     bufod_clock,
    output logic                     bufod_miso,
    output logic                     bufod_cs,
    output logic                     bufod_aux,
    inout  wire                      bufio_mosi,
    inout  wire                      bufio_clock,
    inout  wire                      bufio_miso,
    inout  wire                      bufio_cs,
    inout  wire                      bufio_aux,
    output logic [7:0]               lat,
    output logic                     lat_oe,
    input  logic                     mc_ce,
    input  logic                     mc_oe,
    input  logic                     mc_we,
    input  logic [MC_ADD_WIDTH-1:0]  mc_add,
    inout  wire  [MC_DATA_WIDTH-1:0] mc_data,
    output logic                     irq0,
    output logic                     irq1,
    output logic                     sram_clock,
    output logic                     sram0_cs,
    output logic                     sram1_cs,
    inout  wire  [3:0]               sram0_sio,
    inout  wire  [3:0]               sram1_sio
);

    // Bus synchronizers: bit 2 of we is the edge-detect delay stage
    logic [2:0]               we_sync_q;
    logic [1:0]               ce_sync_q;
    logic [MC_ADD_WIDTH-1:0]  wr_add_q;
    logic [MC_DATA_WIDTH-1:0] wr_data_q;

    // Register file
    logic [4:0]  dir_q,      dir_d;
    logic [4:0]  od_q,       od_d;
    logic [4:0]  out_q,      out_d;
    logic [7:0]  lat_q,      lat_d;
    logic        laten_q,    laten_d;
    logic [1:0]  irqen_q,    irqen_d;
    logic [1:0]  irqstat_q,  irqstat_d;
    logic [4:0]  edgemask_q, edgemask_d;
    logic [15:0] scratch_q,  scratch_d;
    logic [4:0]  in_prev_q;
    logic [1:0]  irq_q;

    logic [4:0]  w_in;
    logic        w_commit;
    logic [31:0] w_wsel;
    logic [15:0] w_wdata;
    logic [1:0]  w_irq_clr;
    logic [1:0]  w_irq_set;
    logic        w_sw_set;
    logic [15:0] w_rdata;
    logic        w_rd_en;

    // ------------------------------------------------------------------
    // Pin buffers
    // ------------------------------------------------------------------
    buspirate_iobuf u_iobuf_mosi (
        .clk_i(clock), .rst_ni(reset),
        .dir_i(dir_q[PIN_MOSI]), .od_i(od_q[PIN_MOSI]), .out_i(out_q[PIN_MOSI]),
        .bufdir_o(bufdir_mosi), .bufod_o(bufod_mosi), .in_o(w_in[PIN_MOSI]),
        .bufio_io(bufio_mosi)
    );
    buspirate_iobuf u_iobuf_clock (
        .clk_i(clock), .rst_ni(reset),
        .dir_i(dir_q[PIN_CLOCK]), .od_i(od_q[PIN_CLOCK]), .out_i(out_q[PIN_CLOCK]),
        .bufdir_o(bufdir_clock), .bufod_o(bufod_clock), .in_o(w_in[PIN_CLOCK]),
        .bufio_io(bufio_clock)
    );
    buspirate_iobuf u_iobuf_miso (
        .clk_i(clock), .rst_ni(reset),
        .dir_i(dir_q[PIN_MISO]), .od_i(od_q[PIN_MISO]), .out_i(out_q[PIN_MISO]),
        .bufdir_o(bufdir_miso), .bufod_o(bufod_miso), .in_o(w_in[PIN_MISO]),
        .bufio_io(bufio_miso)
    );
    buspirate_iobuf u_iobuf_cs (
        .clk_i(clock), .rst_ni(reset),
        .dir_i(dir_q[PIN_CS]), .od_i(od_q[PIN_CS]), .out_i(out_q[PIN_CS]),
        .bufdir_o(bufdir_cs), .bufod_o(bufod_cs), .in_o(w_in[PIN_CS]),
        .bufio_io(bufio_cs)
    );
    buspirate_iobuf u_iobuf_aux (
        .clk_i(clock), .rst_ni(reset),
        .dir_i(dir_q[PIN_AUX]), .od_i(od_q[PIN_AUX]), .out_i(out_q[PIN_AUX]),
        .bufdir_o(bufdir_aux), .bufod_o(bufod_aux), .in_o(w_in[PIN_AUX]),
        .bufio_io(bufio_aux)
    );

    // ------------------------------------------------------------------
    // Bus write path
    // ------------------------------------------------------------------

    // Strobe synchronizers idle high so reset cannot fabricate a write edge
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            we_sync_q <= 3'b111;
            ce_sync_q <= 2'b11;
        end else begin
            we_sync_q <= {we_sync_q[1:0], mc_we};
            ce_sync_q <= {ce_sync_q[0], mc_ce};
        end
    end

    // Hold address/data while the synchronized write strobe is low
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_add_q  <= '0;
            wr_data_q <= '0;
        end else if (!we_sync_q[1]) begin
            wr_add_q  <= mc_add;
            wr_data_q <= mc_data;
        end
    end

    assign w_commit = we_sync_q[1] & ~we_sync_q[2] & ~ce_sync_q[1];
    assign w_wsel   = 32'(wr_add_q);
    assign w_wdata  = wr_data_q[15:0];

    // Register next-state: bus writes plus interrupt set/clear (set wins)
    always_comb begin
        dir_d      = dir_q;
        od_d       = od_q;
        out_d      = out_q;
        lat_d      = lat_q;
        laten_d    = laten_q;
        irqen_d    = irqen_q;
        edgemask_d = edgemask_q;
        scratch_d  = scratch_q;
        w_irq_clr  = 2'b00;
        w_sw_set   = 1'b0;
        if (w_commit) begin
            case (w_wsel)
                REG_DIR:      dir_d      = w_wdata[4:0];
                REG_OD:       od_d       = w_wdata[4:0];
                REG_OUT:      out_d      = w_wdata[4:0];
                REG_LAT: begin
                    lat_d   = w_wdata[7:0];
                    laten_d = w_wdata[8];
                end
                REG_IRQEN:    irqen_d    = w_wdata[1:0];
                REG_IRQSTAT:  w_irq_clr  = w_wdata[1:0];
                REG_EDGEMASK: edgemask_d = w_wdata[4:0];
                REG_SWIRQ:    w_sw_set   = 1'b1;
                REG_SCRATCH:  scratch_d  = w_wdata;
                default: ;
            endcase
        end
        w_irq_set[IRQ_EDGE] = |((w_in ^ in_prev_q) & edgemask_q);
        w_irq_set[IRQ_SW]   = w_sw_set;
        irqstat_d           = (irqstat_q & ~w_irq_clr) | w_irq_set;
    end

    // Register file state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dir_q      <= '0;
            od_q       <= '0;
            out_q      <= '0;
            lat_q      <= '0;
            laten_q    <= 1'b0;
            irqen_q    <= '0;
            irqstat_q  <= '0;
            edgemask_q <= '0;
            scratch_q  <= '0;
            in_prev_q  <= '0;
            irq_q      <= '0;
        end else begin
            dir_q      <= dir_d;
            od_q       <= od_d;
            out_q      <= out_d;
            lat_q      <= lat_d;
            laten_q    <= laten_d;
            irqen_q    <= irqen_d;
            irqstat_q  <= irqstat_d;
            edgemask_q <= edgemask_d;
            scratch_q  <= scratch_d;
            in_prev_q  <= w_in;
            irq_q      <= irqstat_q & irqen_q;
        end
    end

    // ------------------------------------------------------------------
    // Bus read path (combinational from the raw strobes)
    // ------------------------------------------------------------------

    // Read mux; unmapped and write-only addresses return zero
    always_comb begin
        w_rdata = 16'h0000;
        case (32'(mc_add))
            REG_ID:       w_rdata = C_ID_VALUE;
            REG_DIR:      w_rdata = {11'b0, dir_q};
            REG_OD:       w_rdata = {11'b0, od_q};
            REG_OUT:      w_rdata = {11'b0, out_q};
            REG_IN:       w_rdata = {11'b0, w_in};
            REG_LAT:      w_rdata = {7'b0, laten_q, lat_q};
            REG_IRQEN:    w_rdata = {14'b0, irqen_q};
            REG_IRQSTAT:  w_rdata = {14'b0, irqstat_q};
            REG_EDGEMASK: w_rdata = {11'b0, edgemask_q};
            REG_SCRATCH:  w_rdata = scratch_q;
            default:      w_rdata = 16'h0000;
        endcase
    end

    assign w_rd_en = ~mc_ce & ~mc_oe & mc_we;
    assign mc_data = w_rd_en ? MC_DATA_WIDTH'(w_rdata) : {MC_DATA_WIDTH{1'bz}};

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign lat    = lat_q;
    assign lat_oe = ~laten_q;
    assign irq0   = irq_q[0];
    assign irq1   = irq_q[1];

    // Serial SRAM interface is parked
    assign sram_clock = 1'b0;
    assign sram0_cs   = 1'b1;
    assign sram1_cs   = 1'b1;
    assign sram0_sio  = 4'bzzzz;
    assign sram1_sio  = 4'bzzzz;

endmodule : buspirate_top
`default_nettype wire

// File: tb/tb_buspirate_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buspirate_top
//  Description : Directed self-checking bench for buspirate_top with an
//                inline pin PHY model (pull-up, contention detect).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buspirate_top;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic bufdir_mosi, bufdir_clock, bufdir_miso, bufdir_cs, bufdir_aux;
    logic bufod_mosi, bufod_clock, bufod_miso, bufod_cs, bufod_aux;
    wire  bufio_mosi, bufio_clock, bufio_miso, bufio_cs, bufio_aux;
    logic [7:0] lat;
    logic       lat_oe;
    logic       mc_ce = 1'b1;
    logic       mc_oe = 1'b1;
    logic       mc_we = 1'b1;
    logic [5:0] mc_add = 6'd0;
    wire  [15:0] mc_data;
    logic [15:0] tb_data = 16'h0000;
    logic        tb_data_oe = 1'b0;
    logic irq0, irq1, sram_clock, sram0_cs, sram1_cs;
    wire  [3:0] sram0_sio, sram1_sio;

    assign mc_data = tb_data_oe ? tb_data : 16'hzzzz;

    // PHY model: iopin_z marks an undriven (floating) external input
    logic [4:0] iopin_in = 5'b00000;
    logic [4:0] iopin_z  = 5'b00000;
    logic [4:0] w_bufdir, w_bufio, phy_drv, iopin_state, iopin_contention;

    assign w_bufdir = {bufdir_aux, bufdir_cs, bufdir_miso, bufdir_clock, bufdir_mosi};
    assign w_bufio  = {bufio_aux, bufio_cs, bufio_miso, bufio_clock, bufio_mosi};
    assign phy_drv  = iopin_z | iopin_in;
    assign iopin_state      = (w_bufdir & w_bufio) | (~w_bufdir & phy_drv);
    assign iopin_contention = w_bufdir & ~iopin_z & (iopin_in ^ w_bufio);

    assign bufio_mosi  = bufdir_mosi  ? 1'bz : phy_drv[0];
    assign bufio_clock = bufdir_clock ? 1'bz : phy_drv[1];
    assign bufio_miso  = bufdir_miso  ? 1'bz : phy_drv[2];
    assign bufio_cs    = bufdir_cs    ? 1'bz : phy_drv[3];
    assign bufio_aux   = bufdir_aux   ? 1'bz : phy_drv[4];

    buspirate_top #(.MC_DATA_WIDTH(16), .MC_ADD_WIDTH(6)) dut (
        .clock(clock), .reset(reset),
        .bufdir_mosi(bufdir_mosi), .bufdir_clock(bufdir_clock), .bufdir_miso(bufdir_miso),
        .bufdir_cs(bufdir_cs), .bufdir_aux(bufdir_aux),
        .bufod_mosi(bufod_mosi), .bufod_clock(bufod_clock), .bufod_miso(bufod_miso),
        .bufod_cs(bufod_cs), .bufod_aux(bufod_aux),
        .bufio_mosi(bufio_mosi), .bufio_clock(bufio_clock), .bufio_miso(bufio_miso),
        .bufio_cs(bufio_cs), .bufio_aux(bufio_aux),
        .lat(lat), .lat_oe(lat_oe),
        .mc_ce(mc_ce), .mc_oe(mc_oe), .mc_we(mc_we), .mc_add(mc_add), .mc_data(mc_data),
        .irq0(irq0), .irq1(irq1),
        .sram_clock(sram_clock), .sram0_cs(sram0_cs), .sram1_cs(sram1_cs),
        .sram0_sio(sram0_sio), .sram1_sio(sram1_sio)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic bus_write(input logic [5:0] a, input logic [15:0] d);
        @(posedge clock);
        #1;
        mc_add     = a;
        tb_data    = d;
        tb_data_oe = 1'b1;
        mc_oe      = 1'b1;
        mc_ce      = 1'b0;
        mc_we      = 1'b0;
        tick(4);
        mc_we      = 1'b1;
        tick(4);
        mc_ce      = 1'b1;
        tb_data_oe = 1'b0;
        tick(2);
    endtask

    task automatic bus_read(input logic [5:0] a, output logic [15:0] d);
        @(posedge clock);
        #1;
        mc_add = a;
        mc_we  = 1'b1;
        mc_ce  = 1'b0;
        mc_oe  = 1'b0;
        @(negedge clock);
        d     = mc_data;
        mc_ce = 1'b1;
        mc_oe = 1'b1;
        #1;
    endtask

    task automatic read_check(input string tag, input logic [5:0] a, input logic [15:0] exp);
        logic [15:0] d;
        bus_read(a, d);
        check(tag, {16'h0, d}, {16'h0, exp});
    endtask

    initial begin
        // Reset state
        tick(3);
        check("rst_bufdir", {27'b0, w_bufdir}, 32'h0);
        check("rst_bufod", {27'b0, bufod_aux, bufod_cs, bufod_miso, bufod_clock, bufod_mosi}, 32'h0);
        check("rst_lat", {24'b0, lat}, 32'h0);
        check("rst_lat_oe", {31'b0, lat_oe}, 32'h1);
        check("rst_irq", {30'b0, irq1, irq0}, 32'h0);
        check("sram_idle", {29'b0, sram_clock, sram0_cs, sram1_cs}, 32'h3);
        reset = 1'b1;
        tick(3);
        read_check("id", 6'h00, 16'h4250);
        check("bufdir_after_rel", {27'b0, w_bufdir}, 32'h0);
        check("lat_oe_after_rel", {31'b0, lat_oe}, 32'h1);

        // Push-pull drive on aux, external line floating
        iopin_z = 5'b10000;
        bus_write(6'h01, 16'h0010);
        bus_write(6'h03, 16'h0010);
        read_check("dir_rb", 6'h01, 16'h0010);
        check("pp_bufdir_aux", {31'b0, bufdir_aux}, 32'h1);
        check("pp_bufio_aux", {31'b0, bufio_aux}, 32'h1);
        check("pp_state_aux", {31'b0, iopin_state[4]}, 32'h1);
        check("pp_no_cont", {31'b0, iopin_contention[4]}, 32'h0);
        iopin_z[4]  = 1'b0;
        iopin_in[4] = 1'b0;
        tick(1);
        check("pp_contention", {31'b0, iopin_contention[4]}, 32'h1);
        iopin_z[4] = 1'b1;

        // Open-drain on aux
        bus_write(6'h02, 16'h0010);
        bus_write(6'h03, 16'h0000);
        check("od_bufod_aux", {31'b0, bufod_aux}, 32'h1);
        check("od_low_bufdir", {31'b0, bufdir_aux}, 32'h1);
        check("od_low_bufio", {31'b0, bufio_aux}, 32'h0);
        bus_write(6'h03, 16'h0010);
        check("od_high_bufdir", {31'b0, bufdir_aux}, 32'h0);
        check("od_high_pullup", {31'b0, iopin_state[4]}, 32'h1);

        // Input path through the synchronizer
        bus_write(6'h02, 16'h0000);
        bus_write(6'h01, 16'h0000);
        iopin_z[4]  = 1'b0;
        iopin_in[4] = 1'b0;
        tick(4);
        read_check("in_low", 6'h04, 16'h0000);
        iopin_in[4] = 1'b1;
        tick(4);
        read_check("in_high", 6'h04, 16'h0010);

        // Edge interrupt, clear, software interrupt
        bus_write(6'h08, 16'h0010);
        bus_write(6'h06, 16'h0001);
        check("irq0_idle", {31'b0, irq0}, 32'h0);
        iopin_in[4] = 1'b0;
        tick(8);
        check("irq0_edge", {31'b0, irq0}, 32'h1);
        read_check("irqstat_edge", 6'h07, 16'h0001);
        bus_write(6'h07, 16'h0001);
        tick(3);
        check("irq0_cleared", {31'b0, irq0}, 32'h0);
        bus_write(6'h06, 16'h0003);
        bus_write(6'h09, 16'h0000);
        tick(3);
        check("irq1_sw", {31'b0, irq1}, 32'h1);
        check("irq0_still_clr", {31'b0, irq0}, 32'h0);
        read_check("irqstat_sw", 6'h07, 16'h0002);

        // Latch, read-only / unmapped handling, scratch
        bus_write(6'h05, 16'h01A5);
        check("lat_val", {24'b0, lat}, 32'hA5);
        check("lat_oe_on", {31'b0, lat_oe}, 32'h0);
        read_check("lat_rb", 6'h05, 16'h01A5);
        read_check("unmapped", 6'h3F, 16'h0000);
        read_check("swirq_wo", 6'h09, 16'h0000);
        bus_write(6'h00, 16'hFFFF);
        read_check("id_ro", 6'h00, 16'h4250);
        bus_write(6'h0A, 16'hBEEF);
        read_check("scratch", 6'h0A, 16'hBEEF);

        // Bus noise with the write strobe idle must not write anything
        tb_data_oe = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            mc_add  = 6'($urandom);
            tb_data = 16'($urandom);
            mc_ce   = 1'($urandom);
            tick(1);
        end
        mc_ce      = 1'b1;
        tb_data_oe = 1'b0;
        tick(2);
        read_check("idle_scratch", 6'h0A, 16'hBEEF);
        read_check("idle_lat", 6'h05, 16'h01A5);
        read_check("idle_dir", 6'h01, 16'h0000);

        // Write interrupted by reset is discarded
        @(posedge clock);
        #1;
        mc_add     = 6'h0A;
        tb_data    = 16'h1234;
        tb_data_oe = 1'b1;
        mc_ce      = 1'b0;
        mc_we      = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(2);
        mc_we = 1'b1;
        tick(2);
        reset = 1'b1;
        tick(4);
        mc_ce      = 1'b1;
        tb_data_oe = 1'b0;
        tick(2);
        read_check("rst_discard", 6'h0A, 16'h0000);
        check("rst2_lat_oe", {31'b0, lat_oe}, 32'h1);
        check("rst2_irq", {30'b0, irq1, irq0}, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_buspirate_top
`default_nettype wire
